ysyx_22041207_mul: RTL and testbench

- Iterative radix-2 shift-add 64x64 multiplier inside the CPU ALU; serves RV64 MUL.
- Returns the low 64 bits of the product, split into two 32-bit halves.
- Low 64 bits are identical for signed and unsigned operands, so no signedness input exists.
- Multi-cycle with a valid/ready start handshake and a one-cycle done pulse; the ALU stalls the pipeline until the done pulse arrives.

---
 rtl/ysyx_22041207_mul.sv | 133 +++++++++++++
 tb/tb_ysyx_22041207_mul.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22041207_mul.sv
// Iterative radix-2 shift-add multiplier returning the low XLEN bits of a*b.
// One partial product per cycle; fixed XLEN iterations, then a one-cycle
// result-valid pulse. The low product bits do not depend on signedness.
module ysyx_22041207_mul #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mul_valid,
  input  logic            flush,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            mul_ready,
  output logic            mul_out_valid,
  output logic [31:0]     mul_hi,
  output logic [31:0]     mul_lo
);

  localparam int unsigned CntW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     hi_q, hi_d;
  logic [31:0]     lo_q, lo_d;
  logic            out_valid_q, out_valid_d;

  logic iter_done;

  // All XLEN partial products have been accumulated; the next BUSY edge
  // publishes the result instead of iterating.
  assign iter_done = (cnt_q == CntW'(XLEN));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush returns to idle from any state.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (mul_valid) state_d = StBusy;
        StBusy:  if (iter_done) state_d = StDone;
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs decoded from state.
  always_comb begin
    mul_ready = (state_q == StIdle);
  end

  // Datapath next-state: operand load, shift-add step, result capture.
  always_comb begin
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    out_valid_d = 1'b0;
    if (!flush) begin
      unique case (state_q)
        StIdle: begin
          if (mul_valid) begin
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
          end
        end
        StBusy: begin
          if (!iter_done) begin
            if (mplier_q[0]) acc_d = acc_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CntW'(1);
          end else begin
            hi_d        = acc_q[63:32];
            lo_d        = acc_q[31:0];
            out_valid_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign mul_out_valid = out_valid_q;
  assign mul_hi        = hi_q;
  assign mul_lo        = lo_q;

endmodule

// File: tb/tb_ysyx_22041207_mul.sv
// Directed bench for ysyx_22041207_mul: vector table plus latency, flush,
// back-to-back and asynchronous-reset sequences.
module tb_ysyx_22041207_mul;

  logic        clk;
  logic        rst;
  logic        mul_valid;
  logic        flush;
  logic [63:0] a;
  logic [63:0] b;
  logic        mul_ready;
  logic        mul_out_valid;
  logic [31:0] mul_hi;
  logic [31:0] mul_lo;

  int ncmp;
  int nfail;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[5];

  ysyx_22041207_mul #(.XLEN(64)) dut (
    .clk           (clk),
    .rst           (rst),
    .mul_valid     (mul_valid),
    .flush         (flush),
    .a             (a),
    .b             (b),
    .mul_ready     (mul_ready),
    .mul_out_valid (mul_out_valid),
    .mul_hi        (mul_hi),
    .mul_lo        (mul_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance past the next rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation from IDLE and check latency, pulse width and result.
  task automatic run_op(input string name, input logic [63:0] va, input logic [63:0] vb,
                        input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    a = va;
    b = vb;
    mul_valid = 1'b1;
    tick();
    mul_valid = 1'b0;
    check({name, " ready_low"}, {63'd0, mul_ready}, 64'd0);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      n++;
      if (mul_out_valid) break;
    end
    check({name, " latency"}, 64'(n), 64'd65);
    check({name, " valid"}, {63'd0, mul_out_valid}, 64'd1);
    check({name, " hi"}, {32'd0, mul_hi}, {32'd0, ehi});
    check({name, " lo"}, {32'd0, mul_lo}, {32'd0, elo});
    tick();
    check({name, " pulse_end"}, {63'd0, mul_out_valid}, 64'd0);
    check({name, " ready_back"}, {63'd0, mul_ready}, 64'd1);
  endtask

  initial begin
    int pulses;
    int p1;
    int p2;
    logic [31:0] lo1;
    logic [31:0] lo2;

    ncmp  = 0;
    nfail = 0;

    vecs[0] = '{a: 64'd3, b: 64'd5, hi: 32'h0, lo: 32'hF};
    vecs[1] = '{a: 64'hFFFF_FFFF_FFFF_FFFF, b: 64'd2, hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFE};
    vecs[2] = '{a: 64'hFFFF_FFFF_FFFF_FFFF, b: 64'hFFFF_FFFF_FFFF_FFFF, hi: 32'h0, lo: 32'h1};
    vecs[3] = '{a: 64'h1_0000_0000, b: 64'h1_0000_0000, hi: 32'h0, lo: 32'h0};
    vecs[4] = '{a: 64'h1234_5678, b: 64'h10, hi: 32'h1, lo: 32'h2345_6780};

    rst       = 1'b1;
    mul_valid = 1'b0;
    flush     = 1'b0;
    a         = '0;
    b         = '0;
    #2;
    check("reset ready", {63'd0, mul_ready}, 64'd1);
    check("reset valid", {63'd0, mul_out_valid}, 64'd0);
    check("reset hi", {32'd0, mul_hi}, 64'd0);
    check("reset lo", {32'd0, mul_lo}, 64'd0);
    #10;
    rst = 1'b0;
    tick();

    foreach (vecs[i]) run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

    // Flush at BUSY edge 10: no pulse, result registers keep 0x1_2345_6780.
    a = 64'd7;
    b = 64'd6;
    mul_valid = 1'b1;
    tick();
    mul_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush ready", {63'd0, mul_ready}, 64'd1);
    pulses = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (mul_out_valid) pulses++;
    end
    check("flush no_pulse", 64'(pulses), 64'd0);
    check("flush hi_hold", {32'd0, mul_hi}, 64'h1);
    check("flush lo_hold", {32'd0, mul_lo}, 64'h2345_6780);
    run_op("after_flush", 64'd2, 64'd3, 32'h0, 32'h6);

    // Continuous mul_valid with changing operands before each later edge.
    a = 64'd10;
    b = 64'd20;
    mul_valid = 1'b1;
    tick();
    pulses = 0;
    p1 = -1;
    p2 = -1;
    lo1 = '0;
    lo2 = '0;
    for (int k = 1; k <= 140; k++) begin
      a = 64'(k + 2);
      b = 64'd3;
      tick();
      if (mul_out_valid) begin
        pulses++;
        if (p1 < 0) begin
          p1 = k;
          lo1 = mul_lo;
        end else if (p2 < 0) begin
          p2 = k;
          lo2 = mul_lo;
        end
      end
    end
    mul_valid = 1'b0;
    check("b2b pulses", 64'(pulses), 64'd2);
    check("b2b first_edge", 64'(p1), 64'd65);
    check("b2b spacing", 64'(p2 - p1), 64'd67);
    check("b2b first_lo", {32'd0, lo1}, 64'd200);
    check("b2b second_lo", {32'd0, lo2}, 64'd207);

    // Third op accepted at edge 134 is mid-BUSY; reset between edges.
    check("pre_rst busy", {63'd0, mul_ready}, 64'd0);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst ready", {63'd0, mul_ready}, 64'd1);
    check("async_rst valid", {63'd0, mul_out_valid}, 64'd0);
    check("async_rst hi", {32'd0, mul_hi}, 64'd0);
    check("async_rst lo", {32'd0, mul_lo}, 64'd0);
    #2;
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (mul_out_valid) pulses++;
    end
    check("post_rst no_pulse", 64'(pulses), 64'd0);

    // mul_valid together with flush in IDLE never accepts.
    mul_valid = 1'b1;
    flush = 1'b1;
    a = 64'd9;
    b = 64'd9;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("vflush ready", {63'd0, mul_ready}, 64'd1);
    end
    mul_valid = 1'b0;
    flush = 1'b0;
    pulses = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (mul_out_valid) pulses++;
    end
    check("vflush no_pulse", 64'(pulses), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
